// File: rtl/router_pkg.sv
// Shared mesh-router types: router position in the mesh, output direction,
// XY route selection and per-position route legality.
package router_pkg;

    typedef enum logic [3:0] {
        MIDDLE,
        CORNERNW,
        CORNERNE,
        CORNERSW,
        CORNERSE,
        SIDEN,
        SIDES,
        SIDEE,
        SIDEW
    } router_type;

    typedef enum logic [2:0] {
        N     = 3'd0,
        E     = 3'd1,
        S     = 3'd2,
        W     = 3'd3,
        LOCAL = 3'd4
    } dir_t;

    // X is resolved before Y; Y grows southward.
    function automatic dir_t route_xy(input int dest_x, input int dest_y,
                                      input int my_x, input int my_y);
        dir_t d;
        if (dest_x > my_x)      d = E;
        else if (dest_x < my_x) d = W;
        else if (dest_y > my_y) d = S;
        else if (dest_y < my_y) d = N;
        else                    d = LOCAL;
        return d;
    endfunction

    // Edge routers have no neighbour on their boundary side(s).
    function automatic logic dir_legal(input router_type rt, input dir_t d);
        logic ok;
        ok = 1'b1;
        case (d)
            N:       ok = !(rt inside {CORNERNW, CORNERNE, SIDEN});
            S:       ok = !(rt inside {CORNERSW, CORNERSE, SIDES});
            E:       ok = !(rt inside {CORNERNE, CORNERSE, SIDEE});
            W:       ok = !(rt inside {CORNERNW, CORNERSW, SIDEW});
            default: ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/router_fifo.sv
// First-word-fall-through synchronous FIFO; a pushed word is visible at the
// head on the cycle after the push. Full/empty derive from the registered count.
module router_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    count_q;
    logic [LW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/router_input_buffer.sv
// Router input port: req/ack link receiver feeding a FWFT flit buffer, with XY
// route of the head flit and drop-on-illegal-route toward the crossbar.
//
// state    | meaning
// HS_IDLE  | four-phase: waiting for in_req with FIFO space
// HS_ACKED | four-phase: flit written, in_ack high, waiting for in_req low
module router_input_buffer
    import router_pkg::*;
#(
    parameter int         WIDTH       = 32,
    parameter int         DEPTH       = 4,
    parameter int         X_BITS      = 4,
    parameter int         Y_BITS      = 4,
    parameter int         MY_X        = 0,
    parameter int         MY_Y        = 0,
    parameter router_type ROUTER_TYPE = MIDDLE,
    parameter int         HS_MODE     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_req,
    output logic                       in_ack,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [2:0]                 out_dir,
    output logic                       route_err,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    typedef enum logic {HS_IDLE, HS_ACKED} hs_state_t;

    hs_state_t         hs_state_q;
    logic              ack_q;
    logic              req_hist_q;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [WIDTH-1:0]  head;
    logic [X_BITS-1:0] dest_x;
    logic [Y_BITS-1:0] dest_y;
    dir_t              head_dir;
    logic              head_legal;

    router_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (in_data),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    always_comb begin
        push = 1'b0;
        if (HS_MODE == 0) begin
            push = (hs_state_q == HS_IDLE) && in_req && !fifo_full;
        end else begin
            push = (in_req != req_hist_q) && !fifo_full;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hs_state_q <= HS_IDLE;
            ack_q      <= 1'b0;
            req_hist_q <= 1'b0;
        end else if (HS_MODE == 0) begin
            case (hs_state_q)
                HS_IDLE: begin
                    if (push) begin
                        ack_q      <= 1'b1;
                        hs_state_q <= HS_ACKED;
                    end
                end
                HS_ACKED: begin
                    if (!in_req) begin
                        ack_q      <= 1'b0;
                        hs_state_q <= HS_IDLE;
                    end
                end
                default: hs_state_q <= HS_IDLE;
            endcase
        end else if (push) begin
            // Two-phase: every accepted transition is answered by an ack transition.
            req_hist_q <= in_req;
            ack_q      <= ~ack_q;
        end
    end

    assign dest_x     = head[X_BITS-1:0];
    assign dest_y     = head[X_BITS+Y_BITS-1:X_BITS];
    assign head_dir   = route_xy(int'(dest_x), int'(dest_y), MY_X, MY_Y);
    assign head_legal = dir_legal(ROUTER_TYPE, head_dir);

    // An illegally routed head is discarded immediately so it cannot block the port.
    assign out_valid = !fifo_empty && head_legal;
    assign route_err = !fifo_empty && !head_legal;
    assign pop       = route_err || (out_valid && out_ready);

    assign in_ack   = ack_q;
    assign out_data = head;
    assign out_dir  = head_dir;

endmodule

// File: tb/tb_router_input_buffer.sv
// Directed self-checking bench: four router_input_buffer instances covering
// four-phase, two-phase and edge-position route legality.
module tb_router_input_buffer;

    logic        clk;
    logic        rst_n;
    logic        req   [4];
    logic [31:0] din   [4];
    logic        rdy   [4];
    logic        ack   [4];
    logic        valid [4];
    logic [31:0] dout  [4];
    logic [2:0]  dir   [4];
    logic        err   [4];
    logic [2:0]  lvl   [4];

    int checks;
    int failures;

    router_input_buffer #(.MY_X(2), .MY_Y(2), .ROUTER_TYPE(router_pkg::MIDDLE), .HS_MODE(0)) u_fp (
        .clk(clk), .rst_n(rst_n), .in_req(req[0]), .in_ack(ack[0]), .in_data(din[0]),
        .out_valid(valid[0]), .out_ready(rdy[0]), .out_data(dout[0]), .out_dir(dir[0]),
        .route_err(err[0]), .level(lvl[0]));

    router_input_buffer #(.MY_X(2), .MY_Y(2), .ROUTER_TYPE(router_pkg::MIDDLE), .HS_MODE(1)) u_tp (
        .clk(clk), .rst_n(rst_n), .in_req(req[1]), .in_ack(ack[1]), .in_data(din[1]),
        .out_valid(valid[1]), .out_ready(rdy[1]), .out_data(dout[1]), .out_dir(dir[1]),
        .route_err(err[1]), .level(lvl[1]));

    router_input_buffer #(.MY_X(0), .MY_Y(0), .ROUTER_TYPE(router_pkg::CORNERNW), .HS_MODE(0)) u_nw (
        .clk(clk), .rst_n(rst_n), .in_req(req[2]), .in_ack(ack[2]), .in_data(din[2]),
        .out_valid(valid[2]), .out_ready(rdy[2]), .out_data(dout[2]), .out_dir(dir[2]),
        .route_err(err[2]), .level(lvl[2]));

    router_input_buffer #(.MY_X(1), .MY_Y(3), .ROUTER_TYPE(router_pkg::SIDES), .HS_MODE(0)) u_ss (
        .clk(clk), .rst_n(rst_n), .in_req(req[3]), .in_ack(ack[3]), .in_data(din[3]),
        .out_valid(valid[3]), .out_ready(rdy[3]), .out_data(dout[3]), .out_dir(dir[3]),
        .route_err(err[3]), .level(lvl[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Complete four-phase transfer: ack one cycle after req, drops one cycle after req falls.
    task automatic fp_send(input int i, input logic [31:0] d);
        din[i] = d;
        req[i] = 1'b1;
        tick();
        check("fp_ack_rise", 32'(ack[i]), 32'd1);
        req[i] = 1'b0;
        tick();
        check("fp_ack_fall", 32'(ack[i]), 32'd0);
    endtask

    function automatic logic [31:0] kflit(input int k);
        return 32'hA000_0020 | 32'(k);
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req[i] = 1'b0;
            din[i] = '0;
            rdy[i] = 1'b0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("rst_ack",   32'(ack[0]),   32'd0);
        check("rst_valid", 32'(valid[0]), 32'd0);
        check("rst_err",   32'(err[0]),   32'd0);
        check("rst_level", 32'(lvl[0]),   32'd0);
        check("rst_ack_tp", 32'(ack[1]),  32'd0);

        // Basic transfer: dest (3,2) at (2,2) routes East.
        din[0] = 32'h0000_0023;
        req[0] = 1'b1;
        tick();
        check("basic_ack",   32'(ack[0]),   32'd1);
        check("basic_valid", 32'(valid[0]), 32'd1);
        check("basic_dir",   32'(dir[0]),   32'd1);
        check("basic_data",  dout[0],       32'h0000_0023);
        check("basic_level", 32'(lvl[0]),   32'd1);
        req[0] = 1'b0;
        tick();
        check("basic_ack_fall", 32'(ack[0]), 32'd0);
        rdy[0] = 1'b1;
        tick();
        rdy[0] = 1'b0;
        check("basic_pop_level", 32'(lvl[0]), 32'd0);
        check("basic_pop_valid", 32'(valid[0]), 32'd0);

        // Fill to DEPTH with downstream stalled; fifth request must stall.
        for (int k = 0; k < 4; k++) fp_send(0, kflit(k));
        check("fill_level", 32'(lvl[0]), 32'd4);
        din[0] = kflit(4);
        req[0] = 1'b1;
        tick();
        check("full_stall_ack",   32'(ack[0]), 32'd0);
        check("full_stall_level", 32'(lvl[0]), 32'd4);
        check("full_hold_data",   dout[0],     kflit(0));
        tick();
        check("full_stall_ack2",  32'(ack[0]), 32'd0);
        rdy[0] = 1'b1;
        tick();
        rdy[0] = 1'b0;
        check("full_pop_ack",   32'(ack[0]), 32'd0);
        check("full_pop_level", 32'(lvl[0]), 32'd3);
        check("full_pop_head",  dout[0],     kflit(1));
        check("full_pop_dir",   32'(dir[0]), 32'd3);
        tick();
        check("late_ack",   32'(ack[0]), 32'd1);
        check("late_level", 32'(lvl[0]), 32'd4);
        req[0] = 1'b0;
        tick();
        check("late_ack_fall", 32'(ack[0]), 32'd0);
        rdy[0] = 1'b1;
        for (int k = 1; k < 5; k++) begin
            check("drain_order", dout[0], kflit(k));
            tick();
        end
        rdy[0] = 1'b0;
        check("drain_level", 32'(lvl[0]), 32'd0);
        check("drain_valid", 32'(valid[0]), 32'd0);

        // Simultaneous push and pop at level 2.
        fp_send(0, kflit(5));
        fp_send(0, kflit(6));
        check("pp_pre_level", 32'(lvl[0]), 32'd2);
        din[0] = kflit(7);
        req[0] = 1'b1;
        rdy[0] = 1'b1;
        tick();
        rdy[0] = 1'b0;
        check("pp_level", 32'(lvl[0]), 32'd2);
        check("pp_ack",   32'(ack[0]), 32'd1);
        check("pp_head",  dout[0],     kflit(6));
        req[0] = 1'b0;
        tick();
        rdy[0] = 1'b1;
        check("pp_order0", dout[0], kflit(6));
        tick();
        check("pp_order1", dout[0], kflit(7));
        tick();
        rdy[0] = 1'b0;
        check("pp_drain_level", 32'(lvl[0]), 32'd0);

        // Two-phase link: each req transition is one flit.
        din[1] = 32'hB000_0023;
        req[1] = 1'b1;
        tick();
        check("tp_ack0", 32'(ack[1]), 32'd1);
        check("tp_lvl0", 32'(lvl[1]), 32'd1);
        din[1] = 32'hB100_0022;
        req[1] = 1'b0;
        tick();
        check("tp_ack1", 32'(ack[1]), 32'd0);
        check("tp_lvl1", 32'(lvl[1]), 32'd2);
        din[1] = 32'hB200_0021;
        req[1] = 1'b1;
        tick();
        check("tp_ack2", 32'(ack[1]), 32'd1);
        check("tp_lvl2", 32'(lvl[1]), 32'd3);
        tick();
        tick();
        check("tp_hold_ack", 32'(ack[1]), 32'd1);
        check("tp_hold_lvl", 32'(lvl[1]), 32'd3);
        rdy[1] = 1'b1;
        check("tp_out0", dout[1], 32'hB000_0023);
        check("tp_dir0", 32'(dir[1]), 32'd1);
        tick();
        check("tp_out1", dout[1], 32'hB100_0022);
        check("tp_dir1", 32'(dir[1]), 32'd4);
        tick();
        check("tp_out2", dout[1], 32'hB200_0021);
        tick();
        rdy[1] = 1'b0;
        check("tp_drain_lvl", 32'(lvl[1]), 32'd0);

        // CORNERNW at (0,0): LOCAL and East are legal.
        fp_send(2, 32'h0000_0000);
        check("nw_local_dir",   32'(dir[2]),   32'd4);
        check("nw_local_valid", 32'(valid[2]), 32'd1);
        check("nw_local_err",   32'(err[2]),   32'd0);
        rdy[2] = 1'b1;
        tick();
        rdy[2] = 1'b0;
        check("nw_pop_level", 32'(lvl[2]), 32'd0);
        fp_send(2, 32'h0000_0011);
        check("nw_east_dir",   32'(dir[2]),   32'd1);
        check("nw_east_valid", 32'(valid[2]), 32'd1);

        // SIDES at (1,3): dest (1,4) needs South, which is off the mesh.
        din[3] = 32'h0000_0041;
        req[3] = 1'b1;
        tick();
        check("ss_err_pulse", 32'(err[3]),   32'd1);
        check("ss_err_valid", 32'(valid[3]), 32'd0);
        check("ss_err_level", 32'(lvl[3]),   32'd1);
        check("ss_err_dir",   32'(dir[3]),   32'd2);
        req[3] = 1'b0;
        tick();
        check("ss_err_end",   32'(err[3]), 32'd0);
        check("ss_drop_level", 32'(lvl[3]), 32'd0);
        fp_send(3, 32'h0000_0030);
        check("ss_west_dir",   32'(dir[3]),   32'd3);
        check("ss_west_valid", 32'(valid[3]), 32'd1);
        rdy[3] = 1'b1;
        tick();
        rdy[3] = 1'b0;
        fp_send(3, 32'h0000_0021);
        check("ss_north_dir",   32'(dir[3]),   32'd0);
        check("ss_north_valid", 32'(valid[3]), 32'd1);

        // Reset while ACKED with three flits buffered.
        fp_send(0, kflit(8));
        fp_send(0, kflit(9));
        din[0] = kflit(10);
        req[0] = 1'b1;
        tick();
        check("pre_rst_ack",   32'(ack[0]), 32'd1);
        check("pre_rst_level", 32'(lvl[0]), 32'd3);
        rst_n  = 1'b0;
        req[0] = 1'b0;
        tick();
        check("midrst_ack",   32'(ack[0]),   32'd0);
        check("midrst_valid", 32'(valid[0]), 32'd0);
        check("midrst_level", 32'(lvl[0]),   32'd0);
        rst_n = 1'b1;
        tick();
        din[0] = 32'h0000_0023;
        req[0] = 1'b1;
        tick();
        check("post_rst_ack",   32'(ack[0]), 32'd1);
        check("post_rst_level", 32'(lvl[0]), 32'd1);
        check("post_rst_data",  dout[0],     32'h0000_0023);
        req[0] = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_input_buffer.md
Name: router_input_buffer

Overview:
- Parametrised successor to the mesh router input port: accepts flits over a req/ack link handshake and buffers them in a DEPTH-entry FWFT FIFO.
- Computes the XY-routing output direction of the head flit.
- Presents the head flit to the crossbar/arbiter with valid/ready.
- One instance per router input direction; the ROUTER_TYPE position drives illegal-route detection.

Parameters:
- WIDTH, 32: flit width in bits.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- X_BITS, 4: width of the destination X field.
- Y_BITS, 4: width of the destination Y field.
- MY_X, 0: X coordinate of this router.
- MY_Y, 0: Y coordinate of this router.
- ROUTER_TYPE, MIDDLE: router_pkg::router_type position of this router in the mesh.
- HS_MODE, 0: link protocol; 0 = four-phase req/ack, 1 = two-phase (transition) req/ack.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous reset, active-low.
- in_req  in  1  link request from the upstream router; same clock domain, no synchroniser.
- in_ack  out  1  link acknowledge to the upstream router.
- in_data  in  WIDTH  flit; stable while a request is pending.
- out_valid  out  1  head flit available with a legal route.
- out_ready  in  1  downstream accepts the head flit.
- out_data  out  WIDTH  head flit.
- out_dir  out  3  encoded direction: 0=N, 1=E, 2=S, 3=W, 4=LOCAL.
- route_err  out  1  one-cycle pulse when an illegally routed flit is dropped.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - in_ack=0, out_valid=0, route_err=0, level=0;
  - FIFO pointers cleared, handshake FSM to IDLE, two-phase request-history register to 0.
- Reset mid-transfer drops all FIFO contents and any pending handshake; upstream must restart.
- Flit layout: dest_x = in_data[X_BITS-1:0]; dest_y = in_data[X_BITS+Y_BITS-1:X_BITS]. Y increases southward.
- Four-phase FSM (HS_MODE=0):
  - IDLE: when in_req=1 and not full, write in_data at this edge; next cycle in_ack=1; go to ACKED. When in_req=1 and full, stall in IDLE with in_ack=0.
  - ACKED: when in_req=0, next cycle in_ack=0; go to IDLE. A request held high causes no second write.
- Two-phase mode (HS_MODE=1):
  - A new flit is detected when in_req differs from the history register and the FIFO is not full.
  - At that edge: write in_data, update history, toggle in_ack. Latency is 1 cycle.
  - When full, detection is held off until space is available.
- FIFO: first-word-fall-through; a written flit is visible at the head on the next cycle.
  - Full = (level==DEPTH), computed from registered state.
  - Simultaneous pop and push when full: the push is blocked this cycle (full is registered) and accepted next cycle.
  - Simultaneous pop and push when partially filled: level is unchanged.
  - Pointers wrap modulo DEPTH.
- Route computation (combinational on the head flit), checked in this order:
  - dest_x > MY_X → E;
  - dest_x < MY_X → W;
  - dest_y > MY_Y → S;
  - dest_y < MY_Y → N;
  - otherwise → LOCAL.
- Legality depends on ROUTER_TYPE:
  - N is illegal for CORNERNW, CORNERNE, SIDEN;
  - S is illegal for CORNERSW, CORNERSE, SIDES;
  - E is illegal for CORNERNE, CORNERSE, SIDEE;
  - W is illegal for CORNERNW, CORNERSW, SIDEW.
- Illegal head flit: out_valid stays 0; the flit is popped in the same cycle; route_err pulses 1 for that cycle.
- Legal head flit: out_valid=1. A pop occurs when out_valid and out_ready are both 1. out_data and out_dir hold stable while out_valid=1 and out_ready=0.
- level updates on every push and pop; valid range 0..DEPTH.

Decomposition:
- router_pkg (shared package):
  - router_type (already present);
  - new enum dir_t {N, E, S, W, LOCAL} with 3-bit encoding;
  - function route_xy(dest_x, dest_y, my_x, my_y) returning dir_t;
  - function dir_legal(router_type, dir_t).
- One natural sub-module: router_fifo, a parametrised WIDTH×DEPTH FWFT synchronous FIFO with push, pop, full, empty and level.

Test Plan:
- Four-phase, MIDDLE, MY_X=MY_Y=2: send dest (3,2) → in_ack rises 1 cycle after in_req; head shows out_dir=1 (E), out_valid=1; with out_ready=1 it pops and level returns to 0.
- Fill with out_ready=0, DEPTH=4: 5 requests → 4 acked, 5th req held with in_ack=0, level=4; one out_ready pulse → 5th acked next cycle, level=4.
- Two-phase, HS_MODE=1: toggle in_req 3 times on consecutive handshakes → in_ack toggles 3 times; flits emerge in order; a level-held in_req writes nothing further.
- CORNERNW at (0,0): dest (0,0) → out_dir=4 (LOCAL), legal. Head dest_y < MY_Y is impossible here, so use SIDES at (1,3) with dest (1,4) → S illegal: route_err pulses once, out_valid stays 0, level decrements.
- Simultaneous push and pop at level=2 → level stays 2, ordering preserved.
- Assert rst_n=0 in ACKED with level=3 → next cycle in_ack=0, out_valid=0, level=0, FSM in IDLE.
